// File: rtl/exe_stage_mc_if.sv
`default_nettype none
// ============================================================================
// exe_stage_mc_if : ID->EXE, EXE->MEM, data RAM and bypass bundle
// Revision 1.0
// ============================================================================
interface exe_stage_mc_if #(
  parameter int XLEN = 32
);
  localparam int BE_W = XLEN / 8;

  logic            flush;
  logic            in_valid;
  logic            in_allow;
  logic [XLEN-1:0] in_pc;
  logic [3:0]      in_op;
  logic [XLEN-1:0] in_src1;
  logic [XLEN-1:0] in_src2;
  logic [XLEN-1:0] in_st_data;
  logic            in_mem_en;
  logic            in_mem_we;
  logic [1:0]      in_mem_size;
  logic [4:0]      in_rd;
  logic            in_rf_we;
  logic            in_is_load;
  logic            out_valid;
  logic            out_allow;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_result;
  logic [4:0]      out_rd;
  logic            out_rf_we;
  logic            out_is_load;
  logic [BE_W-1:0] out_be;
  logic            out_ale;
  logic            data_ram_en;
  logic [BE_W-1:0] data_ram_we;
  logic [XLEN-1:0] data_ram_addr;
  logic [XLEN-1:0] data_ram_wdata;
  logic            by_valid;
  logic [4:0]      by_rd;
  logic            by_rf_we;
  logic [XLEN-1:0] by_data;
  logic            by_data_ok;

  modport master (
    output flush, in_valid, in_pc, in_op, in_src1, in_src2, in_st_data,
           in_mem_en, in_mem_we, in_mem_size, in_rd, in_rf_we, in_is_load, out_allow,
    input  in_allow, out_valid, out_pc, out_result, out_rd, out_rf_we, out_is_load,
           out_be, out_ale, data_ram_en, data_ram_we, data_ram_addr, data_ram_wdata,
           by_valid, by_rd, by_rf_we, by_data, by_data_ok
  );

  modport slave (
    input  flush, in_valid, in_pc, in_op, in_src1, in_src2, in_st_data,
           in_mem_en, in_mem_we, in_mem_size, in_rd, in_rf_we, in_is_load, out_allow,
    output in_allow, out_valid, out_pc, out_result, out_rd, out_rf_we, out_is_load,
           out_be, out_ale, data_ram_en, data_ram_we, data_ram_addr, data_ram_wdata,
           by_valid, by_rd, by_rf_we, by_data, by_data_ok
  );
endinterface
`default_nettype wire

// File: rtl/exe_stage_mc.sv
`default_nettype none
// ============================================================================
// exe_stage_mc : multi-cycle execute stage (ALU, iterative divider, LSU request, bypass)
// Revision 1.0
// ============================================================================
module exe_stage_mc #(
  parameter int XLEN   = 32,
  parameter int BE_W   = XLEN / 8,
  parameter bit DIV_EN = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  exe_stage_mc_if.slave bus
);
  localparam int SH_W  = $clog2(XLEN);
  localparam int CNT_W = $clog2(XLEN);

  localparam logic [3:0] OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3, OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLT = 4'd5, OP_SLTU = 4'd6, OP_SLL = 4'd7, OP_SRL = 4'd8;
  localparam logic [3:0] OP_SRA = 4'd9, OP_DIV = 4'd10, OP_DIVU = 4'd11, OP_MOD = 4'd12;
  localparam logic [3:0] OP_MODU = 4'd13, OP_PASS2 = 4'd14;

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, src1_q, src2_q, st_data_q;
  logic [3:0]      op_q;
  logic            mem_en_q, mem_we_q, rf_we_q, is_load_q;
  logic [1:0]      size_q;
  logic [4:0]      rd_q;

  logic            is_div_op, div_done, ready_go, in_allow;
  logic [XLEN-1:0] div_res, sum, alu_res, result;
  logic [SH_W-1:0] shamt;

  assign is_div_op = (op_q >= OP_DIV) && (op_q <= OP_MODU);
  assign ready_go  = ~is_div_op | div_done;
  assign in_allow  = ~valid_q | (ready_go & bus.out_allow);

  always_comb begin
    valid_d = valid_q;
    if (in_allow)  valid_d = bus.in_valid;
    if (bus.flush) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      op_q      <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      st_data_q <= '0;
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      size_q    <= '0;
      rd_q      <= '0;
      rf_we_q   <= 1'b0;
      is_load_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (bus.in_valid && in_allow) begin
        pc_q      <= bus.in_pc;
        op_q      <= bus.in_op;
        src1_q    <= bus.in_src1;
        src2_q    <= bus.in_src2;
        st_data_q <= bus.in_st_data;
        mem_en_q  <= bus.in_mem_en;
        mem_we_q  <= bus.in_mem_we;
        size_q    <= bus.in_mem_size;
        rd_q      <= bus.in_rd;
        rf_we_q   <= bus.in_rf_we;
        is_load_q <= bus.in_is_load;
      end
    end
  end

  assign sum   = src1_q + src2_q;
  assign shamt = src2_q[SH_W-1:0];

  always_comb begin
    alu_res = sum;
    case (op_q)
      OP_SUB:   alu_res = src1_q - src2_q;
      OP_AND:   alu_res = src1_q & src2_q;
      OP_OR:    alu_res = src1_q | src2_q;
      OP_XOR:   alu_res = src1_q ^ src2_q;
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(src1_q) < $signed(src2_q)};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, src1_q < src2_q};
      OP_SLL:   alu_res = src1_q << shamt;
      OP_SRL:   alu_res = src1_q >> shamt;
      OP_SRA:   alu_res = XLEN'($signed(src1_q) >>> shamt);
      OP_DIV, OP_DIVU, OP_MOD, OP_MODU: alu_res = div_res;
      OP_PASS2: alu_res = src2_q;
      default:  alu_res = sum;
    endcase
  end

  assign result = mem_en_q ? sum : alu_res;

  generate
    if (DIV_EN) begin : g_div
      typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} div_state_e;
      div_state_e      state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d;
      logic [XLEN-1:0] a_mag, b_mag, q_fix, r_fix;
      logic [XLEN:0]   rem_sh, rem_sub;
      logic            div_signed, a_neg, b_neg, is_quot;

      assign div_signed = (op_q == OP_DIV) || (op_q == OP_MOD);
      assign is_quot    = (op_q == OP_DIV) || (op_q == OP_DIVU);
      assign a_neg      = div_signed & src1_q[XLEN-1];
      assign b_neg      = div_signed & src2_q[XLEN-1];
      assign a_mag      = a_neg ? -src1_q : src1_q;
      assign b_mag      = b_neg ? -src2_q : src2_q;
      // Dividend bits shift out of the quotient register into the partial remainder.
      assign rem_sh     = {rem_q, quo_q[XLEN-1]};
      assign rem_sub    = rem_sh - {1'b0, dsr_q};

      always_ff @(posedge clk) begin
        if (reset) begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          rem_q   <= '0;
          quo_q   <= '0;
          dsr_q   <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          rem_q   <= rem_d;
          quo_q   <= quo_d;
          dsr_q   <= dsr_d;
        end
      end

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dsr_d   = dsr_q;
        case (state_q)
          S_IDLE: begin
            if (valid_q && is_div_op && !bus.flush) begin
              state_d = S_RUN;
              cnt_d   = '0;
              rem_d   = '0;
              quo_d   = a_mag;
              dsr_d   = b_mag;
            end
          end
          S_RUN: begin
            if (rem_sub[XLEN]) begin
              rem_d = rem_sh[XLEN-1:0];
              quo_d = {quo_q[XLEN-2:0], 1'b0};
            end else begin
              rem_d = rem_sub[XLEN-1:0];
              quo_d = {quo_q[XLEN-2:0], 1'b1};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(XLEN - 1)) state_d = S_DONE;
            if (bus.flush) state_d = S_IDLE;
          end
          S_DONE: begin
            if (bus.out_allow || bus.flush) state_d = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end

      assign q_fix    = (a_neg ^ b_neg) ? -quo_q : quo_q;
      assign r_fix    = a_neg ? -rem_q : rem_q;
      assign div_done = (state_q == S_DONE);

      always_comb begin
        div_res = is_quot ? q_fix : r_fix;
        if (src2_q == '0) div_res = is_quot ? '1 : src1_q;
      end
    end else begin : g_nodiv
      assign div_done = 1'b1;
      assign div_res  = '0;
    end
  endgenerate

  logic [1:0]      size_eff;
  logic [2:0]      lo;
  logic            misalign, ale, ram_en;
  logic [BE_W-1:0] mask, be;
  logic [XLEN-1:0] wdata;

  // Double accesses only exist on the 64-bit datapath.
  assign size_eff = ((XLEN == 32) && (size_q == 2'b11)) ? 2'b10 : size_q;
  assign lo       = (XLEN == 64) ? sum[2:0] : {1'b0, sum[1:0]};

  always_comb begin
    misalign = 1'b0;
    mask     = BE_W'(8'h01);
    wdata    = {BE_W{st_data_q[7:0]}};
    case (size_eff)
      2'b01: begin
        misalign = lo[0];
        mask     = BE_W'(8'h03);
        wdata    = {(XLEN/16){st_data_q[15:0]}};
      end
      2'b10: begin
        misalign = (lo[1:0] != 2'b00);
        mask     = BE_W'(8'h0F);
        wdata    = {(XLEN/32){st_data_q[31:0]}};
      end
      2'b11: begin
        misalign = (lo != 3'b000);
        mask     = BE_W'(8'hFF);
        wdata    = st_data_q;
      end
      default: ;
    endcase
  end

  assign be     = mask << lo;
  assign ale    = valid_q & mem_en_q & misalign;
  assign ram_en = valid_q & ready_go & bus.out_allow & mem_en_q & ~misalign & ~bus.flush;

  assign bus.in_allow       = in_allow;
  assign bus.out_valid      = valid_q & ready_go;
  assign bus.out_pc         = pc_q;
  assign bus.out_result     = result;
  assign bus.out_rd         = rd_q;
  assign bus.out_rf_we      = rf_we_q & ~ale;
  assign bus.out_is_load    = is_load_q;
  assign bus.out_be         = (valid_q & mem_en_q) ? be : '0;
  assign bus.out_ale        = ale;
  assign bus.data_ram_en    = ram_en;
  assign bus.data_ram_we    = (ram_en & mem_we_q) ? be : '0;
  assign bus.data_ram_addr  = sum;
  assign bus.data_ram_wdata = wdata;
  assign bus.by_valid       = valid_q;
  assign bus.by_rd          = rd_q;
  assign bus.by_rf_we       = rf_we_q & ~ale;
  assign bus.by_data        = result;
  assign bus.by_data_ok     = valid_q & ready_go & ~is_load_q;
endmodule
`default_nettype wire

// File: tb/tb_exe_stage_mc.sv
`default_nettype none
// ============================================================================
// tb_exe_stage_mc : directed self-checking bench for exe_stage_mc (XLEN 32 and 64)
// Revision 1.0
// ============================================================================
module tb_exe_stage_mc;
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, XOR = 4'd4, SLT = 4'd5, SLTU = 4'd6;
  localparam logic [3:0] SRL = 4'd8, SRA = 4'd9, DIV = 4'd10, DIVU = 4'd11;
  localparam logic [3:0] MOD = 4'd12, MODU = 4'd13;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  exe_stage_mc_if #(.XLEN(32)) b32 ();
  exe_stage_mc_if #(.XLEN(64)) b64 ();

  exe_stage_mc #(.XLEN(32), .DIV_EN(1'b1)) u_dut32 (.clk(clk), .reset(reset), .bus(b32));
  exe_stage_mc #(.XLEN(64), .DIV_EN(1'b1)) u_dut64 (.clk(clk), .reset(reset), .bus(b64));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] st, input logic men, input logic mwe,
                       input logic [1:0] sz, input logic ld);
    b32.in_valid = 1'b1;   b32.in_op = op;       b32.in_src1 = a;     b32.in_src2 = b;
    b32.in_st_data = st;   b32.in_mem_en = men;  b32.in_mem_we = mwe; b32.in_mem_size = sz;
    b32.in_is_load = ld;   b32.in_pc = 32'h0000_0400; b32.in_rd = 5'd7; b32.in_rf_we = 1'b1;
    #1;
  endtask

  task automatic set64(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] st, input logic men, input logic mwe,
                       input logic [1:0] sz, input logic ld);
    b64.in_valid = 1'b1;   b64.in_op = op;       b64.in_src1 = a;     b64.in_src2 = b;
    b64.in_st_data = st;   b64.in_mem_en = men;  b64.in_mem_we = mwe; b64.in_mem_size = sz;
    b64.in_is_load = ld;   b64.in_pc = 64'h8000_0000_0000_0040; b64.in_rd = 5'd9; b64.in_rf_we = 1'b1;
    #1;
  endtask

  task automatic alu32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    set32(op, a, b, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic div32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string tag);
    int   n;
    logic stalled;
    n = 0;
    stalled = 1'b1;
    alu32(op, a, b);
    cyc();
    b32.in_valid = 1'b0;
    #1;
    while (!b32.out_valid && n < 200) begin
      if (b32.in_allow) stalled = 1'b0;
      cyc();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd33);
    chk({tag, "_stall"}, 64'(stalled), 64'd1);
    chk(tag, 64'(b32.out_result), 64'(exp));
  endtask

  task automatic div64(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input string tag);
    int   n;
    logic stalled;
    n = 0;
    stalled = 1'b1;
    set64(op, a, b, 64'h0, 1'b0, 1'b0, 2'b00, 1'b0);
    cyc();
    b64.in_valid = 1'b0;
    #1;
    while (!b64.out_valid && n < 300) begin
      if (b64.in_allow) stalled = 1'b0;
      cyc();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd65);
    chk({tag, "_stall"}, 64'(stalled), 64'd1);
    chk(tag, b64.out_result, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    b32.flush = 1'b0; b32.out_allow = 1'b1; b64.flush = 1'b0; b64.out_allow = 1'b1;
    set32(ADD, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0);
    set64(ADD, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 2'b00, 1'b0);
    b32.in_valid = 1'b0; b64.in_valid = 1'b0;
    repeat (2) cyc();
    reset = 1'b0;
    #1;
    chk("rst_in_allow", 64'(b32.in_allow), 64'd1);
    chk("rst_result", 64'(b32.out_result), 64'd0);
    chk("rst_be", 64'(b32.out_be), 64'd0);
    chk("rst_flags", 64'({b32.out_valid, b32.out_rf_we, b32.out_is_load, b32.out_ale,
                          b32.data_ram_en, b32.by_valid, b32.by_rf_we, b32.by_data_ok}), 64'd0);

    // Back-to-back single-cycle ALU ops
    alu32(ADD, 32'd5, 32'd7);
    chk("add_allow0", 64'(b32.in_allow), 64'd1);
    cyc(); alu32(SLT, 32'hFFFF_FFFF, 32'd1);
    chk("add", 64'(b32.out_result), 64'd12);
    chk("add_valid", 64'(b32.out_valid), 64'd1);
    chk("add_allow", 64'(b32.in_allow), 64'd1);
    chk("add_pc", 64'(b32.out_pc), 64'h400);
    chk("add_byok", 64'({b32.by_valid, b32.by_rd, b32.by_data_ok}), 64'b1_00111_1);
    cyc(); alu32(SRA, 32'h8000_0000, 32'd4);
    chk("slt", 64'(b32.out_result), 64'd1);
    cyc(); alu32(SLTU, 32'hFFFF_FFFF, 32'd1);
    chk("sra", 64'(b32.out_result), 64'hF800_0000);
    chk("sra_allow", 64'(b32.in_allow), 64'd1);
    cyc(); alu32(SUB, 32'd3, 32'd5);
    chk("sltu", 64'(b32.out_result), 64'd0);
    cyc(); alu32(SRL, 32'h8000_0000, 32'd36);
    chk("sub", 64'(b32.out_result), 64'hFFFF_FFFE);
    cyc(); alu32(XOR, 32'h0000_F0F0, 32'h0000_0FF0);
    chk("srl", 64'(b32.out_result), 64'h0800_0000);
    cyc(); b32.in_valid = 1'b0; #1;
    chk("xor", 64'(b32.out_result), 64'h0000_FF00);
    cyc();

    // Iterative divider, each new op captured behind the accepted one
    div32(DIV,  32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, "div");
    div32(MOD,  32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, "mod");
    div32(DIVU, 32'd7,         32'd0,          32'hFFFF_FFFF, "divu0");
    div32(MOD,  32'h8000_0000, 32'hFFFF_FFFF,  32'h0,         "modmin");
    div32(DIV,  32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, "divmin");
    div32(MODU, 32'd7,         32'd0,          32'd7,         "modu0");
    div32(DIVU, 32'd100,       32'd7,          32'd14,        "divu");
    b32.in_valid = 1'b0; #1;
    cyc();

    // Stores and load
    set32(ADD, 32'h1000, 32'd3, 32'h0000_00AB, 1'b1, 1'b1, 2'b00, 1'b0);
    cyc(); set32(ADD, 32'h1000, 32'd2, 32'h0000_1234, 1'b1, 1'b1, 2'b01, 1'b0);
    chk("sb_en", 64'(b32.data_ram_en), 64'd1);
    chk("sb_we", 64'(b32.data_ram_we), 64'b1000);
    chk("sb_wdata", 64'(b32.data_ram_wdata), 64'hABAB_ABAB);
    chk("sb_addr", 64'(b32.data_ram_addr), 64'h1003);
    cyc(); set32(ADD, 32'h1000, 32'd2, 32'hCAFE_F00D, 1'b1, 1'b1, 2'b10, 1'b0);
    chk("sh_we", 64'(b32.data_ram_we), 64'b1100);
    chk("sh_wdata", 64'(b32.data_ram_wdata), 64'h1234_1234);
    cyc(); set32(ADD, 32'h1000, 32'd4, 32'h0, 1'b1, 1'b0, 2'b10, 1'b1);
    chk("sw_mis_ale", 64'(b32.out_ale), 64'd1);
    chk("sw_mis_en", 64'(b32.data_ram_en), 64'd0);
    chk("sw_mis_rfwe", 64'({b32.out_rf_we, b32.by_rf_we}), 64'd0);
    chk("sw_mis_valid", 64'(b32.out_valid), 64'd1);
    cyc(); b32.in_valid = 1'b0; #1;
    chk("lw_en_we", 64'({b32.data_ram_en, b32.data_ram_we}), 64'b1_0000);
    chk("lw_load", 64'({b32.out_is_load, b32.by_data_ok}), 64'b10);
    chk("lw_addr", 64'(b32.out_result), 64'h1004);
    cyc();

    // Back-pressure from MEM
    b32.out_allow = 1'b0;
    set32(ADD, 32'h2000, 32'd4, 32'h55, 1'b1, 1'b1, 2'b10, 1'b0);
    cyc(); alu32(ADD, 32'd1, 32'd2);
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", 64'(b32.out_valid), 64'd1);
      chk("bp_ram_en", 64'(b32.data_ram_en), 64'd0);
      chk("bp_allow", 64'(b32.in_allow), 64'd0);
      chk("bp_addr", 64'(b32.out_result), 64'h2004);
      cyc();
    end
    b32.out_allow = 1'b1; #1;
    chk("bp_rel_en", 64'(b32.data_ram_en), 64'd1);
    chk("bp_rel_we", 64'(b32.data_ram_we), 64'hF);
    chk("bp_rel_allow", 64'(b32.in_allow), 64'd1);
    cyc(); b32.in_valid = 1'b0; #1;
    chk("bp_next", 64'(b32.out_result), 64'd3);
    cyc();

    // Flush during divider RUN
    alu32(DIV, 32'd100, 32'd7);
    cyc(); b32.in_valid = 1'b0; #1;
    repeat (10) cyc();
    b32.flush = 1'b1; #1;
    chk("fl_run_valid", 64'(b32.out_valid), 64'd0);
    cyc(); b32.flush = 1'b0; #1;
    chk("fl_valid", 64'({b32.out_valid, b32.by_valid}), 64'd0);
    chk("fl_allow", 64'(b32.in_allow), 64'd1);
    alu32(ADD, 32'd1, 32'd1);
    cyc();
    chk("fl_add", 64'(b32.out_result), 64'd2);
    chk("fl_add_valid", 64'(b32.out_valid), 64'd1);
    div32(DIVU, 32'd100, 32'd7, 32'd14, "fl_div");
    b32.in_valid = 1'b0; #1;
    cyc();

    // Flush kills a pending store and a same-cycle capture
    set32(ADD, 32'h3000, 32'd0, 32'h11, 1'b1, 1'b1, 2'b10, 1'b0);
    cyc(); alu32(ADD, 32'd2, 32'd2);
    b32.flush = 1'b1; #1;
    chk("fl_ram_en", 64'(b32.data_ram_en), 64'd0);
    cyc(); b32.flush = 1'b0; b32.in_valid = 1'b0; #1;
    chk("fl_st_valid", 64'(b32.out_valid), 64'd0);

    // 64-bit datapath
    set64(ADD, 64'h0, 64'h8, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b1, 2'b11, 1'b0);
    cyc(); set64(ADD, 64'h0, 64'hC, 64'h0000_0000_DEAD_BEEF, 1'b1, 1'b1, 2'b10, 1'b0);
    chk("sd_we", 64'(b64.data_ram_we), 64'hFF);
    chk("sd_wdata", b64.data_ram_wdata, 64'h0123_4567_89AB_CDEF);
    chk("sd_en", 64'(b64.data_ram_en), 64'd1);
    cyc(); set64(ADD, 64'h0, 64'hE, 64'h0000_0000_0000_BEEF, 1'b1, 1'b1, 2'b01, 1'b0);
    chk("sw64_we", 64'(b64.data_ram_we), 64'hF0);
    chk("sw64_wdata", b64.data_ram_wdata, 64'hDEAD_BEEF_DEAD_BEEF);
    cyc(); set64(ADD, 64'h0, 64'h4, 64'h0, 1'b1, 1'b1, 2'b11, 1'b0);
    chk("sh64_we", 64'(b64.data_ram_we), 64'hC0);
    chk("sh64_wdata", b64.data_ram_wdata, 64'hBEEF_BEEF_BEEF_BEEF);
    cyc(); b64.in_valid = 1'b0; #1;
    chk("sd_mis", 64'({b64.out_ale, b64.data_ram_en}), 64'b10);
    cyc();
    div64(DIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, "div64");
    b64.in_valid = 1'b0; #1;
    cyc();

    // Reset in the middle of a 64-bit divide
    set64(DIV, 64'd1000, 64'd3, 64'h0, 1'b0, 1'b0, 2'b00, 1'b0);
    cyc(); b64.in_valid = 1'b0; #1;
    repeat (5) cyc();
    reset = 1'b1;
    cyc(); reset = 1'b0; #1;
    chk("rst64_allow", 64'(b64.in_allow), 64'd1);
    chk("rst64_pc", b64.out_pc, 64'd0);
    chk("rst64_result", b64.out_result, 64'd0);
    chk("rst64_by_data", b64.by_data, 64'd0);
    chk("rst64_flags", 64'({b64.out_valid, b64.out_rf_we, b64.out_is_load, b64.out_ale, b64.out_rd,
                            b64.data_ram_en, b64.data_ram_we, b64.out_be, b64.by_valid,
                            b64.by_rd, b64.by_rf_we, b64.by_data_ok}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/exe_stage_mc.md
Name: exe_stage_mc

Overview:
Parametrised execute stage sitting between ID and MEM in the in-order pipeline; successor to the single-cycle execute stage.
- Adds an iterative divider, so the stage becomes multi-cycle with real back-pressure.
- Generalises datapath width (32/64) and byte-enable generation, with store-data lane replication and misalignment detection.
- Supports a synchronous pipeline flush.
- Drives the data RAM request and the EXE bypass bus.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
BE_W, XLEN/8, byte-enable width (derived; do not override).
DIV_EN, 1, 1 = iterative divider present; 0 = div/mod ops return 0 in one cycle.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
flush  in  1  synchronous kill of the instruction held in this stage
in_valid  in  1  ID has an instruction for EXE
in_allow  out  1  EXE can accept this cycle
in_pc  in  XLEN  instruction PC
in_op  in  4  0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLT,6 SLTU,7 SLL,8 SRL,9 SRA,10 DIV,11 DIVU,12 MOD,13 MODU,14 PASS2,15 reserved (=ADD)
in_src1, in_src2  in  XLEN  operands
in_st_data  in  XLEN  store data
in_mem_en, in_mem_we  in  1  memory access / store
in_mem_size  in  2  00 byte, 01 half, 10 word, 11 double (XLEN=64 only; treated as word when XLEN=32)
in_rd  in  5  destination register
in_rf_we  in  1  register write enable
in_is_load  in  1  result comes from memory
out_valid  out  1  EXE has a result for MEM
out_allow  in  1  MEM can accept
out_pc, out_result  out  XLEN  PC and ALU/div result (address for memory ops)
out_rd  out  5  destination register
out_rf_we  out  1  register write enable
out_is_load  out  1  load flag
out_be  out  BE_W  byte enables
out_ale  out  1  address-misaligned exception
data_ram_en  out  1  data RAM enable
data_ram_we  out  BE_W  data RAM byte write enables
data_ram_addr  out  XLEN  data RAM address
data_ram_wdata  out  XLEN  data RAM write data
by_valid, by_rd, by_rf_we  out  1/5/1  bypass qualifiers
by_data  out  XLEN  bypass data
by_data_ok  out  1  bypass data is final

Behaviour:
Reset and flush
- reset: valid=0, divider FSM=IDLE, captured fields=0. Every output then reads 0 except in_allow=1.
- flush: valid<=0 and FSM<=IDLE next edge, overriding any capture in the same cycle. No RAM request is issued in a flush cycle.

Handshake
- ready_go = ~is_div_op | div_done.
- in_allow = ~valid | (ready_go & out_allow).
- out_valid = valid & ready_go.
- Capture fields when in_valid & in_allow.
- valid <= in_valid when in_allow.

ALU (combinational)
- Shifts use src2[log2(XLEN)-1:0].
- SLT is signed; SLTU is unsigned.

Divider FSM (DIV_EN=1): IDLE -> RUN -> DONE.
- IDLE -> RUN on the first cycle valid & div op & ~flush.
- RUN: restoring radix-2, one quotient bit per cycle, for XLEN cycles.
- DONE holds the result; div_done=1 while in DONE.
- DONE -> IDLE when the result is accepted (out_allow) or on flush.
- Latency: result presented XLEN+1 cycles after capture (33 for XLEN=32).
- Signed ops: divide magnitudes, then fix signs (quotient negative iff signs differ; remainder takes the dividend's sign).
- Divide by zero: quotient = all ones; remainder = dividend.
- MIN/-1 (signed): quotient = MIN; remainder = 0.
- A new divide captured directly behind an accepted one restarts from IDLE; there are no stale results.

Memory
- addr = ALU sum.
- Misalignment: half with addr[0]≠0, word with addr[1:0]≠0, double with addr[2:0]≠0.
- be = size mask (1, 3, F, FF) shifted left by the addr low bits (addr[1:0] for XLEN=32, addr[2:0] for XLEN=64).
- wdata: byte replicated to all lanes, half to every halfword, word to both words (XLEN=64).
- data_ram_en = valid & ready_go & out_allow & mem_en & ~misalign & ~flush.
- data_ram_we = mem_we ? be : 0.
- On misalignment: out_ale=1, out_rf_we=0, no RAM access, and the instruction still flows to MEM.

Bypass
- by_valid = valid; by_rd = rd; by_rf_we = rf_we & ~ale.
- by_data = result.
- by_data_ok = ready_go & ~is_load.

Test Plan:
- ADD 5+7, then SLT -1<1, SRA 0x80000000>>4, back-to-back with out_allow=1 -> results 12, 1, 0xF8000000 on consecutive cycles; in_allow stays 1.
- DIV -7/2, DIVU 7/0, MOD 0x80000000%-1, each with out_allow=1 -> -3 (rem check via MOD -7%2 = -1), 0xFFFFFFFF, 0. out_valid rises exactly 33 cycles after capture; in_allow=0 meanwhile.
- Stores: SB 0xAB at addr 0x1003 -> we=1000, wdata 0xABABABAB. SH 0x1234 at 0x1002 -> we=1100, wdata 0x12341234. SW at 0x1002 -> ale=1, data_ram_en=0, rf_we=0.
- out_allow held 0 for 3 cycles with ADD valid -> outputs stable, in_allow=0, no RAM request; the request fires on the release cycle only.
- flush asserted on RUN cycle 10 of a DIV -> next cycle valid=0, FSM IDLE; a following ADD 1+1 returns 2 with one-cycle latency.
- XLEN=64: SD at 0x8 -> we=0xFF; SW 0xDEADBEEF at 0xC -> we=0xF0, wdata 0xDEADBEEFDEADBEEF; reset asserted mid-DIV -> all outputs 0 and in_allow=1 next cycle.
